// File: rtl/tug_pkg.sv
// Shared types for the push-ball match referee: FSM state encoding, winner codes
// and the width helper used to size the ball position register.
package tug_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COUNTDOWN  = 3'd1,
        PLAY       = 3'd2,
        POINT      = 3'd3,
        MATCH_OVER = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } winner_t;

    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/tug_tick_gen.sv
// Free-running game tick divider: pulses tick for one clock out of every
// TICK_CYCLES, starting from zero at reset.
module tug_tick_gen
    import tug_pkg::*;
#(
    parameter int TICK_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    output logic tick
);

    localparam int DW = clog2(TICK_CYCLES);
    localparam logic [DW-1:0] LAST = DW'(TICK_CYCLES - 1);

    logic [DW-1:0] divider;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            divider <= '0;
        end else if (divider == LAST) begin
            divider <= '0;
        end else begin
            divider <= divider + 1'b1;
        end
    end

    assign tick = (divider == LAST);

endmodule

// File: rtl/tug_match_ctrl.sv
// Match referee for the push-ball LED game: countdown, arbitrated moves, wall
// scoring with a flashing point display, re-serve and best-of-N match end.
module tug_match_ctrl
    import tug_pkg::*;
#(
    parameter int N_LEDS          = 10,
    parameter int CENTER          = 4,
    parameter int WIN_POINTS      = 3,
    parameter int TICK_CYCLES     = 500000,
    parameter int COUNTDOWN_TICKS = 300,
    parameter int FLASH_TICKS     = 100
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              start,
    input  logic              push_left,
    input  logic              push_right,
    output logic [N_LEDS-1:0] LEDG,
    output logic [3:0]        score_left,
    output logic [3:0]        score_right,
    output logic [2:0]        state,
    output logic [1:0]        winner
);

    localparam int PW = clog2(N_LEDS);
    localparam logic [PW-1:0]     POS_CENTER = PW'(CENTER);
    localparam logic [PW-1:0]     POS_LAST   = PW'(N_LEDS - 1);
    localparam logic [3:0]        WIN_SCORE  = 4'(WIN_POINTS);
    localparam logic [15:0]       CD_LAST    = 16'(COUNTDOWN_TICKS - 1);
    localparam logic [15:0]       FL_LAST    = 16'(FLASH_TICKS - 1);
    localparam logic [N_LEDS-1:0] LED_ONE    = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] CENTER_LED = LED_ONE << CENTER;

    state_t            cur_state, nxt_state;
    winner_t           cur_winner, nxt_winner;
    logic [PW-1:0]     pos, nxt_pos, moved_pos;
    logic [3:0]        nxt_score_left, nxt_score_right;
    logic [15:0]       tick_cnt;
    logic [N_LEDS-1:0] nxt_ledg, pos_led;
    logic              tick;

    tug_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .tick     (tick)
    );

    // tick_cnt restarts whenever the FSM changes state, so each phase times itself
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cur_state   <= IDLE;
            cur_winner  <= NONE;
            pos         <= POS_CENTER;
            score_left  <= '0;
            score_right <= '0;
            tick_cnt    <= '0;
            LEDG        <= CENTER_LED;
        end else begin
            cur_state   <= nxt_state;
            cur_winner  <= nxt_winner;
            pos         <= nxt_pos;
            score_left  <= nxt_score_left;
            score_right <= nxt_score_right;
            LEDG        <= nxt_ledg;
            if (nxt_state != cur_state) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        nxt_state       = cur_state;
        nxt_winner      = cur_winner;
        nxt_pos         = pos;
        nxt_score_left  = score_left;
        nxt_score_right = score_right;
        moved_pos       = pos;
        if (push_right && !push_left && pos != POS_LAST) begin
            moved_pos = pos + 1'b1;
        end else if (push_left && !push_right && pos != '0) begin
            moved_pos = pos - 1'b1;
        end
        case (cur_state)
            IDLE, MATCH_OVER: begin
                if (start) begin
                    nxt_state       = COUNTDOWN;
                    nxt_winner      = NONE;
                    nxt_pos         = POS_CENTER;
                    nxt_score_left  = '0;
                    nxt_score_right = '0;
                end
            end
            COUNTDOWN: begin
                if (tick && tick_cnt == CD_LAST) begin
                    nxt_state = PLAY;
                end
            end
            PLAY: begin
                nxt_pos = moved_pos;
                if (moved_pos != pos && moved_pos == POS_LAST) begin
                    nxt_state = POINT;
                    if (score_right < WIN_SCORE) begin
                        nxt_score_right = score_right + 4'd1;
                    end
                end else if (moved_pos != pos && moved_pos == '0) begin
                    nxt_state = POINT;
                    if (score_left < WIN_SCORE) begin
                        nxt_score_left = score_left + 4'd1;
                    end
                end
            end
            POINT: begin
                // The ball is still parked at the scorer's wall, which identifies the scorer
                if (tick && tick_cnt == FL_LAST) begin
                    if (pos == '0 && score_left == WIN_SCORE) begin
                        nxt_winner = LEFT;
                        nxt_state  = MATCH_OVER;
                    end else if (pos == POS_LAST && score_right == WIN_SCORE) begin
                        nxt_winner = RIGHT;
                        nxt_state  = MATCH_OVER;
                    end else begin
                        nxt_pos   = POS_CENTER;
                        nxt_state = COUNTDOWN;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign pos_led = LED_ONE << pos;

    always_comb begin
        nxt_ledg = '0;
        case (cur_state)
            COUNTDOWN: nxt_ledg = CENTER_LED;
            POINT: begin
                if (!tick_cnt[0]) begin
                    nxt_ledg = pos_led;
                end
            end
            MATCH_OVER: begin
                for (int i = 0; i < N_LEDS; i++) begin
                    nxt_ledg[i] = (cur_winner == LEFT)  ? (i <= CENTER) :
                                  (cur_winner == RIGHT) ? (i >= CENTER) : 1'b0;
                end
            end
            default: nxt_ledg = pos_led;
        endcase
    end

    assign state  = cur_state;
    assign winner = cur_winner;

endmodule

// File: doc/tug_match_ctrl.md
Name: tug_match_ctrl

Overview:
Match referee for the push-ball (tug-of-war) LED game. It takes one-cycle push pulses from both players' debounced buttons and runs the match: start countdown, arbitrated ball moves, wall detection, point award with LED flash, re-centering, and best-of-N match end. It owns the ball position and drives the green LED bar directly, replacing free-running shift logic with a sequenced game.

Parameters:
N_LEDS, 10, LED bar width; ball position range 0..N_LEDS-1.
CENTER, 4, serve position index (bit 4 lit = 10'b0000010000).
WIN_POINTS, 3, points needed to win the match (1..15).
TICK_CYCLES, 500000, clock cycles per game tick (10 ms at 50 MHz).
COUNTDOWN_TICKS, 300, ticks of countdown before play (3 s).
FLASH_TICKS, 100, ticks of point-flash display (1 s).

Ports:
CLOCK_50  in  1  system clock, 50 MHz
RESET_N  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin new match
push_left  in  1  one-cycle pulse: left player pushes ball toward bit 0
push_right  in  1  one-cycle pulse: right player pushes ball toward bit N_LEDS-1
LEDG  out  N_LEDS  ball display
score_left  out  4  left player points
score_right  out  4  right player points
state  out  3  current FSM state (package encoding)
winner  out  2  0 none, 1 left, 2 right

Behaviour:
- Reset (async, RESET_N low): state IDLE, pos=CENTER, LEDG=one-hot(CENTER), scores 0, winner 0, tick divider and tick counter 0.
- Tick: divider counts 0..TICK_CYCLES-1, free-running from reset; tick asserted for 1 cycle when divider==TICK_CYCLES-1. tick_cnt clears on every state entry, increments on tick.
- States: IDLE, COUNTDOWN, PLAY, POINT, MATCH_OVER.
- IDLE: LEDG=one-hot(pos). start -> scores 0, winner 0, pos=CENTER, COUNTDOWN next cycle.
- COUNTDOWN: LEDG=one-hot(CENTER); pushes ignored. On the tick that brings tick_cnt to COUNTDOWN_TICKS -> PLAY next cycle.
- PLAY: push_right only -> pos+1; push_left only -> pos-1; both in same cycle -> cancel, no move; pos updates the cycle after the pulse. If the new pos==N_LEDS-1: score_right+1, pos held at the wall, POINT, all in that same update cycle. If the new pos==0: score_left+1, POINT, likewise. Moves never go beyond 0 or N_LEDS-1.
- POINT: pushes ignored. LEDG=one-hot(pos) while tick_cnt even, all zeros while odd. On the tick reaching FLASH_TICKS: if the scorer's score==WIN_POINTS -> winner set, MATCH_OVER; otherwise pos=CENTER, COUNTDOWN.
- MATCH_OVER: LEDG steady: left winner lights bits [CENTER:0], right winner lights bits [N_LEDS-1:CENTER]. Scores and winner held. start -> same action as in IDLE.
- start is ignored in COUNTDOWN, PLAY and POINT.
- Scores saturate at WIN_POINTS and never wrap.
- RESET_N asserted in any state, mid-move or mid-flash: immediate return to reset values. No pending move survives reset.
- All outputs are registered. LEDG is decoded from pos, state and tick_cnt[0] into a register, giving 1 cycle of latency behind pos.

Decomposition:
- Package tug_pkg holds the state enum and encoding (IDLE=0, COUNTDOWN=1, PLAY=2, POINT=3, MATCH_OVER=4), the winner codes (NONE=0, LEFT=1, RIGHT=2) and the pos width function clog2(N_LEDS).
- One sub-module: tug_tick_gen (parameter TICK_CYCLES, ports CLOCK_50, RESET_N, tick). The FSM, position, score and LED decode stay in tug_match_ctrl.

Test Plan:
Use TICK_CYCLES=4, COUNTDOWN_TICKS=3, FLASH_TICKS=2 and WIN_POINTS=2 for all scenarios.
1. Reset, then start pulse -> state IDLE→COUNTDOWN; LEDG=10'b0000010000; PLAY entered after 3 ticks (12 cycles ±divider phase); push_right during COUNTDOWN leaves pos=4.
2. PLAY: push_right, then push_right -> LEDG 0000100000, then 0001000000, each 1 cycle + 1 LED-register cycle after its pulse. push_left and push_right in the same cycle -> no change.
3. PLAY from pos 4: 5 push_right pulses -> pos=9, score_right=1, state POINT; LEDG alternates 1000000000/0 per tick; after 2 ticks state COUNTDOWN with pos=4.
4. Left wins 2 points (4 push_left pulses per point) -> score_left=2, MATCH_OVER, winner=1, LEDG=0000011111. Extra pushes change nothing. start -> scores 0, winner 0, COUNTDOWN.
5. Assert RESET_N mid-POINT flash and mid-PLAY -> all outputs at reset values immediately; state IDLE; start pulse is needed to resume.
6. start pulses during PLAY and POINT -> ignored: state, scores and pos unchanged.
